// File: rtl/ram_port_ctrl.sv
// Request sequencer and sole bus master for a single-port RAM with a
// two-cycle registered read; also keeps wrapping write/read counters.
`timescale 1ns/1ps
module ram_port_ctrl #(
    parameter int AW    = 8,
    parameter int DW    = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  logic             req_we_i,
    input  logic [AW-1:0]    req_addr_i,
    input  logic [DW-1:0]    req_wdata_i,
    output logic             rsp_valid_o,
    input  logic             rsp_ready_i,
    output logic [DW-1:0]    rsp_rdata_o,
    output logic             ram_wr_en_o,
    output logic             ram_rd_en_o,
    output logic [AW-1:0]    ram_addr_o,
    inout  wire  [DW-1:0]    ram_data_io,
    output logic [CNT_W-1:0] wr_cnt_o,
    output logic [CNT_W-1:0] rd_cnt_o
);

    typedef enum logic [2:0] {IDLE, WR, RD1, RD2, RSP} state_t;

    state_t           state_reg, state_next;
    logic             ready_reg;
    logic             valid_reg;
    logic             wr_en_reg;
    logic             rd_en_reg;
    logic             drive_reg;
    logic [AW-1:0]    addr_reg;
    logic [DW-1:0]    wdata_reg;
    logic [DW-1:0]    rdata_reg;
    logic [CNT_W-1:0] wr_cnt_reg;
    logic [CNT_W-1:0] rd_cnt_reg;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (req_valid_i) state_next = req_we_i ? WR : RD1;
            WR:      state_next = IDLE;
            RD1:     state_next = RD2;
            RD2:     state_next = RSP;
            RSP:     if (rsp_ready_i) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Output flags are decoded from the next state so they are true
    // flops aligned with the state they describe.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg  <= IDLE;
            ready_reg  <= 1'b1;
            valid_reg  <= 1'b0;
            wr_en_reg  <= 1'b0;
            rd_en_reg  <= 1'b0;
            drive_reg  <= 1'b0;
            addr_reg   <= '0;
            wdata_reg  <= '0;
            rdata_reg  <= '0;
            wr_cnt_reg <= '0;
            rd_cnt_reg <= '0;
        end else begin
            state_reg <= state_next;
            ready_reg <= (state_next == IDLE);
            valid_reg <= (state_next == RSP);
            wr_en_reg <= (state_next == WR);
            drive_reg <= (state_next == WR);
            rd_en_reg <= (state_next == RD1) || (state_next == RD2);
            if (state_reg == IDLE && req_valid_i) begin
                addr_reg  <= req_addr_i;
                wdata_reg <= req_wdata_i;
            end
            // RAM drives its output register onto the bus during RD2.
            if (state_reg == RD2) rdata_reg <= ram_data_io;
            if (state_reg == WR) wr_cnt_reg <= wr_cnt_reg + CNT_W'(1);
            if (state_reg == RSP && rsp_ready_i) rd_cnt_reg <= rd_cnt_reg + CNT_W'(1);
        end
    end

    assign ram_data_io = drive_reg ? wdata_reg : {DW{1'bz}};
    assign req_ready_o = ready_reg;
    assign rsp_valid_o = valid_reg;
    assign rsp_rdata_o = rdata_reg;
    assign ram_wr_en_o = wr_en_reg;
    assign ram_rd_en_o = rd_en_reg;
    assign ram_addr_o  = addr_reg;
    assign wr_cnt_o    = wr_cnt_reg;
    assign rd_cnt_o    = rd_cnt_reg;

endmodule

// File: tb/tb_ram_port_ctrl.sv
// Directed bench for ram_port_ctrl with a behavioural two-cycle-read RAM;
// a second instance with 4-bit counters shares the request inputs.
`timescale 1ns/1ps
module tb_ram_port_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_we = 1'b0;
    logic [7:0]  req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        rsp_ready = 1'b1;

    logic        req_ready, rsp_valid, ram_wr_en, ram_rd_en;
    logic [31:0] rsp_rdata;
    logic [7:0]  ram_addr;
    logic [15:0] wr_cnt, rd_cnt;
    wire  [31:0] bus;

    logic        req_ready_4, rsp_valid_4, ram_wr_en_4, ram_rd_en_4;
    logic [31:0] rsp_rdata_4;
    logic [7:0]  ram_addr_4;
    logic [3:0]  wr_cnt_4, rd_cnt_4;
    wire  [31:0] bus_4;

    int n_cmp = 0;
    int n_err = 0;
    int mon_err = 0;
    logic prev_rd = 1'b0;

    always #5 clk = ~clk;

    ram_port_ctrl #(.AW(8), .DW(32), .CNT_W(16)) u_dut (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(req_valid), .req_ready_o(req_ready), .req_we_i(req_we),
        .req_addr_i(req_addr), .req_wdata_i(req_wdata),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_rdata_o(rsp_rdata),
        .ram_wr_en_o(ram_wr_en), .ram_rd_en_o(ram_rd_en), .ram_addr_o(ram_addr),
        .ram_data_io(bus), .wr_cnt_o(wr_cnt), .rd_cnt_o(rd_cnt)
    );

    ram_port_ctrl #(.AW(8), .DW(32), .CNT_W(4)) u_dut4 (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(req_valid), .req_ready_o(req_ready_4), .req_we_i(req_we),
        .req_addr_i(req_addr), .req_wdata_i(req_wdata),
        .rsp_valid_o(rsp_valid_4), .rsp_ready_i(rsp_ready), .rsp_rdata_o(rsp_rdata_4),
        .ram_wr_en_o(ram_wr_en_4), .ram_rd_en_o(ram_rd_en_4), .ram_addr_o(ram_addr_4),
        .ram_data_io(bus_4), .wr_cnt_o(wr_cnt_4), .rd_cnt_o(rd_cnt_4)
    );

    // RAM model: output register loads while rd_en is high, drives bus while rd_en is high.
    logic [31:0] mem [256];
    logic [31:0] ram_q = '0;
    always @(posedge clk) begin
        if (ram_wr_en) mem[ram_addr] <= bus;
        if (ram_rd_en) ram_q <= mem[ram_addr];
    end
    assign bus = ram_rd_en ? ram_q : 32'bz;

    // Bus-ownership monitor: no overlap of enables, and a gap cycle after any read.
    always @(negedge clk) begin
        if (!rst) begin
            if (ram_wr_en && ram_rd_en) mon_err <= mon_err + 1;
            if (ram_wr_en && prev_rd)   mon_err <= mon_err + 1;
        end
        prev_rd <= ram_rd_en;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    // Drive one request at a negedge in IDLE; returns at the negedge after acceptance.
    task automatic issue(input logic we, input logic [7:0] a, input logic [31:0] d);
        req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = d;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic wait_rsp(output int lat);
        lat = 0;
        while (!rsp_valid && lat < 10) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_cmp++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %b expected 1", req_ready); end
        n_cmp++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b expected 0", rsp_valid); end
        n_cmp++; if (rsp_rdata !== 32'h0) begin n_err++; $display("FAIL reset_rdata: got %h expected 0", rsp_rdata); end
        n_cmp++; if ({ram_wr_en, ram_rd_en} !== 2'b00) begin n_err++; $display("FAIL reset_en: got %b expected 00", {ram_wr_en, ram_rd_en}); end
        n_cmp++; if (ram_addr !== 8'h0) begin n_err++; $display("FAIL reset_addr: got %h expected 0", ram_addr); end
        n_cmp++; if (wr_cnt !== 16'd0 || rd_cnt !== 16'd0) begin n_err++; $display("FAIL reset_cnt: got %0d/%0d expected 0/0", wr_cnt, rd_cnt); end
        rst = 1'b0;
        @(negedge clk);
        n_cmp++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL post_reset_ready: got %b expected 1", req_ready); end
    endtask

    task automatic test_write_read();
        int lat;
        issue(1'b1, 8'h10, 32'hDEADBEEF);
        n_cmp++; if (ram_wr_en !== 1'b1 || bus !== 32'hDEADBEEF || ram_addr !== 8'h10) begin
            n_err++; $display("FAIL wr_cycle: got en=%b bus=%h addr=%h expected 1 deadbeef 10", ram_wr_en, bus, ram_addr); end
        n_cmp++; if (req_ready !== 1'b0) begin n_err++; $display("FAIL wr_ready: got %b expected 0", req_ready); end
        @(negedge clk);
        n_cmp++; if (ram_wr_en !== 1'b0) begin n_err++; $display("FAIL wr_one_cycle: got %b expected 0", ram_wr_en); end
        n_cmp++; if (wr_cnt !== 16'd1 || req_ready !== 1'b1) begin n_err++; $display("FAIL wr_done: got cnt=%0d rdy=%b expected 1 1", wr_cnt, req_ready); end
        issue(1'b0, 8'h10, 32'h0);
        n_cmp++; if (ram_rd_en !== 1'b1 || rsp_valid !== 1'b0) begin n_err++; $display("FAIL rd1: got rd=%b v=%b expected 1 0", ram_rd_en, rsp_valid); end
        wait_rsp(lat);
        n_cmp++; if (lat !== 2) begin n_err++; $display("FAIL rd_latency: got %0d expected 2", lat); end
        n_cmp++; if (rsp_rdata !== 32'hDEADBEEF) begin n_err++; $display("FAIL rd_data: got %h expected deadbeef", rsp_rdata); end
        n_cmp++; if (ram_rd_en !== 1'b0 || req_ready !== 1'b0) begin n_err++; $display("FAIL rsp_state: got rd=%b rdy=%b expected 0 0", ram_rd_en, req_ready); end
        @(negedge clk);
        n_cmp++; if (rd_cnt !== 16'd1 || rsp_valid !== 1'b0) begin n_err++; $display("FAIL rd_done: got cnt=%0d v=%b expected 1 0", rd_cnt, rsp_valid); end
    endtask

    task automatic test_back_to_back();
        int lat;
        logic [31:0] exp_d;
        for (int i = 0; i < 256; i++) begin
            issue(1'b1, 8'(i), 32'(i) * 32'h01010101);
            n_cmp++; if (req_ready !== 1'b0) begin n_err++; $display("FAIL b2b_ready_low[%0d]: got %b expected 0", i, req_ready); end
            @(negedge clk);
            n_cmp++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL b2b_ready_high[%0d]: got %b expected 1", i, req_ready); end
        end
        for (int i = 0; i < 256; i++) begin
            exp_d = 32'(i) * 32'h01010101;
            issue(1'b0, 8'(i), 32'h0);
            wait_rsp(lat);
            n_cmp++; if (lat !== 2 || rsp_rdata !== exp_d) begin
                n_err++; $display("FAIL b2b_read[%0d]: got %h lat %0d expected %h lat 2", i, rsp_rdata, lat, exp_d); end
            @(negedge clk);
        end
        n_cmp++; if (wr_cnt !== 16'd257 || rd_cnt !== 16'd257) begin n_err++; $display("FAIL b2b_cnt: got %0d/%0d expected 257/257", wr_cnt, rd_cnt); end
    endtask

    task automatic test_stall();
        int lat;
        rsp_ready = 1'b0;
        issue(1'b0, 8'h20, 32'h0);
        wait_rsp(lat);
        for (int i = 0; i < 5; i++) begin
            n_cmp++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h20202020 || req_ready !== 1'b0) begin
                n_err++; $display("FAIL stall_hold[%0d]: got v=%b d=%h rdy=%b expected 1 20202020 0", i, rsp_valid, rsp_rdata, req_ready); end
            @(negedge clk);
        end
        n_cmp++; if (rd_cnt !== 16'd257) begin n_err++; $display("FAIL stall_cnt_hold: got %0d expected 257", rd_cnt); end
        rsp_ready = 1'b1;
        n_cmp++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h20202020) begin n_err++; $display("FAIL stall_6th: got v=%b d=%h expected 1 20202020", rsp_valid, rsp_rdata); end
        @(negedge clk);
        n_cmp++; if (rd_cnt !== 16'd258 || rsp_valid !== 1'b0) begin n_err++; $display("FAIL stall_done: got cnt=%0d v=%b expected 258 0", rd_cnt, rsp_valid); end
    endtask

    task automatic test_turnaround();
        int lat;
        issue(1'b0, 8'h30, 32'h0);
        wait_rsp(lat);
        n_cmp++; if (rsp_rdata !== 32'h30303030) begin n_err++; $display("FAIL ta_read1: got %h expected 30303030", rsp_rdata); end
        @(negedge clk);
        issue(1'b1, 8'h30, 32'hA5A50030);
        @(negedge clk);
        issue(1'b0, 8'h30, 32'h0);
        wait_rsp(lat);
        n_cmp++; if (rsp_rdata !== 32'hA5A50030) begin n_err++; $display("FAIL ta_read2: got %h expected a5a50030", rsp_rdata); end
        @(negedge clk);
        n_cmp++; if (mon_err !== 0) begin n_err++; $display("FAIL bus_ownership: got %0d violations expected 0", mon_err); end
        n_cmp++; if (wr_cnt !== 16'd258 || rd_cnt !== 16'd260) begin n_err++; $display("FAIL ta_cnt: got %0d/%0d expected 258/260", wr_cnt, rd_cnt); end
    endtask

    task automatic test_reset_in_rd2();
        int lat;
        int seen_valid;
        issue(1'b0, 8'h40, 32'h0);
        @(negedge clk);
        // In RD2: reset together with a competing write request.
        rst = 1'b1;
        req_valid = 1'b1; req_we = 1'b1; req_addr = 8'h55; req_wdata = 32'h12345678;
        @(negedge clk);
        rst = 1'b0;
        req_valid = 1'b0;
        n_cmp++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || ram_rd_en !== 1'b0 || ram_wr_en !== 1'b0) begin
            n_err++; $display("FAIL rst_rd2_state: got rdy=%b v=%b rd=%b wr=%b expected 1 0 0 0", req_ready, rsp_valid, ram_rd_en, ram_wr_en); end
        n_cmp++; if (wr_cnt !== 16'd0 || rd_cnt !== 16'd0 || ram_addr !== 8'h0 || rsp_rdata !== 32'h0) begin
            n_err++; $display("FAIL rst_rd2_values: got %0d/%0d addr=%h d=%h expected 0/0 00 0", wr_cnt, rd_cnt, ram_addr, rsp_rdata); end
        seen_valid = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (rsp_valid || ram_wr_en) seen_valid++;
        end
        n_cmp++; if (seen_valid !== 0) begin n_err++; $display("FAIL rst_rd2_quiet: got %0d active cycles expected 0", seen_valid); end
        issue(1'b0, 8'h55, 32'h0);
        wait_rsp(lat);
        n_cmp++; if (lat !== 2 || rsp_rdata !== 32'h55555555) begin
            n_err++; $display("FAIL rst_rd2_reread: got %h lat %0d expected 55555555 lat 2", rsp_rdata, lat); end
        @(negedge clk);
        n_cmp++; if (rd_cnt !== 16'd1 || wr_cnt !== 16'd0) begin n_err++; $display("FAIL rst_rd2_cnt: got %0d/%0d expected 0/1", wr_cnt, rd_cnt); end
    endtask

    task automatic test_wrap();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 17; i++) begin
            issue(1'b1, 8'(8'h70 + i), 32'(i));
            @(negedge clk);
            if (i == 14) begin
                n_cmp++; if (wr_cnt_4 !== 4'd15) begin n_err++; $display("FAIL wrap_15: got %0d expected 15", wr_cnt_4); end
            end
            if (i == 15) begin
                n_cmp++; if (wr_cnt_4 !== 4'd0) begin n_err++; $display("FAIL wrap_16: got %0d expected 0", wr_cnt_4); end
            end
        end
        n_cmp++; if (wr_cnt_4 !== 4'd1) begin n_err++; $display("FAIL wrap_17: got %0d expected 1", wr_cnt_4); end
        n_cmp++; if (wr_cnt !== 16'd17) begin n_err++; $display("FAIL wide_17: got %0d expected 17", wr_cnt); end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_back_to_back();
        test_stall();
        test_turnaround();
        test_reset_in_rd2();
        test_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
